// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_pkg                                                   |
// | Description : Shared constants and state encoding for the UART blocks.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int FRAME_BITS           = 10;
  localparam int DEFAULT_CLKS_PER_BIT = 104;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sync_fifo                                                  |
// | Description : Single-clock show-ahead FIFO, wrap-bit pointer full/empty. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_wr;
  logic             w_do_rd;

  // Same index with opposite wrap bits means the writer has lapped the reader.
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_wr = wr_en && !full;
  assign w_do_rd = rd_en && !empty;
  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_tx                                                    |
// | Description : 8N1 UART transmitter, LSB first, fed from a byte FIFO.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       TXD,
  output logic       busy
);

  localparam int              CW     = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]   c_last = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      c_last_bit = 3'(DATA_BITS - 1);

  state_t      r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]  r_bit_idx, w_bit_idx_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_txd, w_txd_nxt;

  logic        w_pop;
  logic [7:0]  w_fifo_data;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic        w_bit_end;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (tx_valid),
    .wr_data (tx_data),
    .rd_en   (w_pop),
    .rd_data (w_fifo_data),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

  assign w_bit_end = (r_cnt == c_last);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_txd_nxt     = r_txd;
    w_pop         = 1'b0;

    case (r_state)
      IDLE: begin
        w_txd_nxt = 1'b1;
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_data;
          w_state_nxt = START;
          w_cnt_nxt   = '0;
          w_txd_nxt   = 1'b0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt   = DATA;
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = '0;
          w_txd_nxt     = r_shift[0];
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (r_bit_idx == c_last_bit) begin
            w_state_nxt = STOP;
            w_txd_nxt   = 1'b1;
          end else begin
            // shift[0] always mirrors the bit currently on the line
            w_shift_nxt   = {1'b0, r_shift[7:1]};
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_txd_nxt     = r_shift[1];
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_data;
            w_state_nxt = START;
            w_txd_nxt   = 1'b0;
          end else begin
            w_state_nxt = IDLE;
            w_txd_nxt   = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_txd     <= w_txd_nxt;
    end
  end

  assign TXD      = r_txd;
  assign tx_ready = !w_fifo_full;
  assign busy     = (r_state != IDLE) || !w_fifo_empty;

endmodule
`default_nettype wire
